// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: streams a program out of the instruction buffer
// into a small prefetch FIFO that feeds the decoder, one word per cycle.
module inst_fetch_ctrl #(
    parameter int ADDR_WD    = 12,
    parameter int DATA_WD    = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [ADDR_WD-1:0] i_start_addr,
    input  logic [ADDR_WD:0]   i_inst_num,
    input  logic               i_abort,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_inst_rd_en,
    output logic [ADDR_WD-1:0] o_inst_raddr,
    input  logic [DATA_WD-1:0] i_inst_rdat,
    input  logic               i_inst_rdat_vld,
    output logic [DATA_WD-1:0] o_inst,
    output logic [ADDR_WD-1:0] o_inst_pc,
    output logic               o_inst_vld,
    input  logic               i_inst_rdy
);
    // state | meaning
    // IDLE  | waiting for i_start
    // FETCH | issuing reads, limited by FIFO credit
    // DRAIN | all reads issued, waiting for returns and FIFO to empty
    // FLUSH | aborted, discarding in-flight returns

    localparam int PTR_WD = $clog2(FIFO_DEPTH);
    localparam int CNT_WD = PTR_WD + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FLUSH} state_t;
    state_t state_q, state_d;

    logic [ADDR_WD-1:0] raddr_q;
    logic [ADDR_WD-1:0] rd_pc_q;
    logic [ADDR_WD:0]   issued_q;
    logic [ADDR_WD:0]   num_q;
    logic [CNT_WD-1:0]  out_q;
    logic [CNT_WD-1:0]  cnt_q;
    logic [PTR_WD-1:0]  wr_ptr_q;
    logic [PTR_WD-1:0]  rd_ptr_q;
    logic               done_q;
    logic               done_d;
    logic [DATA_WD-1:0] mem_data [FIFO_DEPTH];
    logic [ADDR_WD-1:0] mem_pc   [FIFO_DEPTH];

    logic               fifo_vld;
    logic               pop;
    logic               ret;
    logic               active;
    logic               clr;
    logic               push;
    logic               start_ok;
    logic               credit_ok;
    logic               rd_en;
    logic               last_rd;
    logic [CNT_WD:0]    occ;
    logic [ADDR_WD:0]   issued_inc;

    assign fifo_vld   = (cnt_q != '0);
    assign pop        = fifo_vld & i_inst_rdy;
    // a return with nothing outstanding is stray and never reaches the FIFO
    assign ret        = i_inst_rdat_vld & (out_q != '0);
    assign active     = (state_q == FETCH) || (state_q == DRAIN);
    assign clr        = active & i_abort;
    assign push       = ret & active & ~i_abort;
    assign start_ok   = (state_q == IDLE) & i_start & ~i_abort;
    assign occ        = {1'b0, cnt_q} + {1'b0, out_q} - {{CNT_WD{1'b0}}, pop};
    assign credit_ok  = (occ < (CNT_WD+1)'(FIFO_DEPTH));
    assign issued_inc = issued_q + {{ADDR_WD{1'b0}}, 1'b1};
    assign rd_en      = (state_q == FETCH) & ~i_abort & (issued_q < num_q) & credit_ok;
    assign last_rd    = rd_en & (issued_inc == num_q);

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    if (i_inst_num != '0) state_d = FETCH;
                    else                  done_d  = 1'b1;
                end
            end
            FETCH: begin
                if (i_abort)      state_d = FLUSH;
                else if (last_rd) state_d = DRAIN;
            end
            DRAIN: begin
                if (i_abort) begin
                    state_d = FLUSH;
                end else if (!fifo_vld && out_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            FLUSH: begin
                if (out_q == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            raddr_q  <= '0;
            rd_pc_q  <= '0;
            issued_q <= '0;
            num_q    <= '0;
            out_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= done_d;
            if (start_ok) begin
                raddr_q  <= i_start_addr;
                issued_q <= '0;
                num_q    <= i_inst_num;
            end else if (rd_en) begin
                raddr_q  <= raddr_q + ADDR_WD'(1);
                issued_q <= issued_inc;
                rd_pc_q  <= raddr_q;
            end
            if (rd_en && !ret)      out_q <= out_q + CNT_WD'(1);
            else if (!rd_en && ret) out_q <= out_q - CNT_WD'(1);
            if (clr) begin
                cnt_q    <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_WD'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_WD'(1);
                if (push && !pop)      cnt_q <= cnt_q + CNT_WD'(1);
                else if (!push && pop) cnt_q <= cnt_q - CNT_WD'(1);
            end
        end
    end

    // read latency is fixed at one cycle, so the last issued address tags the return
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_data[wr_ptr_q] <= i_inst_rdat;
            mem_pc[wr_ptr_q]   <= rd_pc_q;
        end
    end

    assign o_busy       = (state_q != IDLE);
    assign o_done       = done_q;
    assign o_inst_rd_en = rd_en;
    assign o_inst_raddr = raddr_q;
    assign o_inst_vld   = fifo_vld;
    assign o_inst       = fifo_vld ? mem_data[rd_ptr_q] : '0;
    assign o_inst_pc    = fifo_vld ? mem_pc[rd_ptr_q] : '0;
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: buffer responder, scoreboard monitor and directed plus
// randomized programs checked against an address-sequence reference model.
module tb_inst_fetch_ctrl;
    localparam int ADDR_WD    = 12;
    localparam int DATA_WD    = 128;
    localparam int FIFO_DEPTH = 4;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_start;
    logic [ADDR_WD-1:0] i_start_addr;
    logic [ADDR_WD:0]   i_inst_num;
    logic               i_abort;
    logic               o_busy;
    logic               o_done;
    logic               o_inst_rd_en;
    logic [ADDR_WD-1:0] o_inst_raddr;
    logic [DATA_WD-1:0] i_inst_rdat;
    logic               i_inst_rdat_vld;
    logic [DATA_WD-1:0] o_inst;
    logic [ADDR_WD-1:0] o_inst_pc;
    logic               o_inst_vld;
    logic               i_inst_rdy;

    inst_fetch_ctrl #(.ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_start_addr(i_start_addr),
        .i_inst_num(i_inst_num), .i_abort(i_abort), .o_busy(o_busy), .o_done(o_done),
        .o_inst_rd_en(o_inst_rd_en), .o_inst_raddr(o_inst_raddr), .i_inst_rdat(i_inst_rdat),
        .i_inst_rdat_vld(i_inst_rdat_vld), .o_inst(o_inst), .o_inst_pc(o_inst_pc),
        .o_inst_vld(o_inst_vld), .i_inst_rdy(i_inst_rdy)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int prog_rd = 0;
    int prog_acc = 0;
    int inject_req = 0;
    bit rand_rdy = 1'b0;
    int rd_cyc_q[$];
    int acc_cyc_q[$];
    logic [ADDR_WD-1:0] exp_rd_q[$];
    logic [ADDR_WD-1:0] exp_pc_q[$];

    always @(posedge i_clk) cyc++;

    function automatic logic [DATA_WD-1:0] word_of(input logic [ADDR_WD-1:0] a);
        logic [31:0] h;
        h = {20'h0, a} * 32'h9E37_79B1;
        return {h, ~h, h ^ 32'h1357_9BDF, {20'hC0DE5, a}};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic chk_d(input string name, input logic [DATA_WD-1:0] act, input logic [DATA_WD-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    // instruction buffer: data appears exactly one cycle after a read enable
    initial begin
        logic               pend;
        logic [ADDR_WD-1:0] pa;
        int                 inject_seen;
        inject_seen     = 0;
        i_inst_rdat_vld = 1'b0;
        i_inst_rdat     = '0;
        forever begin
            @(negedge i_clk);
            pend = o_inst_rd_en;
            pa   = o_inst_raddr;
            @(posedge i_clk);
            #1;
            i_inst_rdat_vld = pend || (inject_req != inject_seen);
            i_inst_rdat     = pend ? word_of(pa) : {$urandom, $urandom, $urandom, $urandom};
            inject_seen     = inject_req;
        end
    end

    // scoreboard monitor
    initial begin
        logic [ADDR_WD-1:0] pc;
        forever begin
            @(negedge i_clk);
            if (o_inst_vld && i_inst_rdy) begin
                prog_acc++;
                acc_cyc_q.push_back(cyc);
                if (exp_pc_q.size() == 0) begin
                    chk("inst_unexpected", 64'(o_inst_pc), 64'hFFFF);
                end else begin
                    pc = exp_pc_q.pop_front();
                    chk("inst_pc", 64'(o_inst_pc), 64'(pc));
                    chk_d("inst_data", o_inst, word_of(pc));
                end
            end
            if (o_inst_rd_en) begin
                rd_cnt++;
                prog_rd++;
                rd_cyc_q.push_back(cyc);
                chk("rd_credit", 64'(prog_rd - prog_acc <= FIFO_DEPTH), 64'(1));
                if (exp_rd_q.size() == 0) chk("rd_unexpected", 64'(o_inst_raddr), 64'hFFFF);
                else chk("rd_addr", 64'(o_inst_raddr), 64'(exp_rd_q.pop_front()));
            end
            if (o_done) begin
                done_cnt++;
                chk("done_with_pending", 64'(exp_pc_q.size() + exp_rd_q.size()), 64'(0));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
        if (rand_rdy) i_inst_rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic start_prog(input logic [ADDR_WD-1:0] addr, input logic [ADDR_WD:0] num);
        prog_rd  = 0;
        prog_acc = 0;
        rd_cyc_q.delete();
        acc_cyc_q.delete();
        for (int i = 0; i < int'(num); i++) begin
            exp_rd_q.push_back(addr + ADDR_WD'(i));
            exp_pc_q.push_back(addr + ADDR_WD'(i));
        end
        i_start      = 1'b1;
        i_start_addr = addr;
        i_inst_num   = num;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_done_seen"}, 64'(done_cnt - d0), 64'(1));
        tick();
        tick();
        chk({name, "_single_done"}, 64'(done_cnt - d0), 64'(1));
        chk({name, "_idle"}, 64'(o_busy), 64'(0));
        chk({name, "_rd_left"}, 64'(exp_rd_q.size()), 64'(0));
        chk({name, "_inst_left"}, 64'(exp_pc_q.size()), 64'(0));
        exp_rd_q.delete();
        exp_pc_q.delete();
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_busy"}, 64'(o_busy), 64'(0));
        chk({name, "_done"}, 64'(o_done), 64'(0));
        chk({name, "_rd_en"}, 64'(o_inst_rd_en), 64'(0));
        chk({name, "_vld"}, 64'(o_inst_vld), 64'(0));
        chk({name, "_raddr"}, 64'(o_inst_raddr), 64'(0));
        chk({name, "_pc"}, 64'(o_inst_pc), 64'(0));
        chk_d({name, "_inst"}, o_inst, '0);
    endtask

    task automatic run_basic(input string name);
        i_inst_rdy = 1'b1;
        start_prog(12'h010, 13'd8);
        wait_done(40, name);
        chk({name, "_rd_count"}, 64'(rd_cyc_q.size()), 64'(8));
        chk({name, "_rd_back2back"}, 64'(rd_cyc_q.size() > 0 ? rd_cyc_q[$] - rd_cyc_q[0] : -1), 64'(7));
        chk({name, "_acc_count"}, 64'(acc_cyc_q.size()), 64'(8));
        chk({name, "_acc_back2back"}, 64'(acc_cyc_q.size() > 0 ? acc_cyc_q[$] - acc_cyc_q[0] : -1), 64'(7));
    endtask

    initial begin
        int d0;
        int r0;
        int n;
        i_rst        = 1'b1;
        i_start      = 1'b0;
        i_abort      = 1'b0;
        i_inst_rdy   = 1'b0;
        i_start_addr = '0;
        i_inst_num   = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check_idle_outputs("reset");
        i_rst = 1'b0;
        inject_req++;
        repeat (4) tick();
        chk("stray_return_vld", 64'(o_inst_vld), 64'(0));
        chk("stray_return_busy", 64'(o_busy), 64'(0));

        run_basic("basic");

        start_prog(12'hFFE, 13'd4);
        wait_done(30, "wrap");

        i_inst_rdy = 1'b0;
        start_prog(12'h400, 13'd10);
        repeat (12) tick();
        chk("credit_reads", 64'(prog_rd), 64'(4));
        chk("credit_rd_low", 64'(o_inst_rd_en), 64'(0));
        chk("credit_vld", 64'(o_inst_vld), 64'(1));
        i_inst_rdy = 1'b1;
        wait_done(60, "credit");
        chk("credit_total", 64'(prog_rd), 64'(10));

        start_prog(12'h300, 13'd20);
        n = 0;
        while (!(prog_acc == 2 && o_inst_vld) && n < 40) begin
            tick();
            n++;
        end
        chk("abort_reached", 64'(n < 40), 64'(1));
        i_abort = 1'b1;
        d0 = done_cnt;
        @(negedge i_clk);
        chk("abort_no_rd", 64'(o_inst_rd_en), 64'(0));
        chk("abort_third_acc", 64'(prog_acc), 64'(3));
        tick();
        i_abort = 1'b0;
        exp_rd_q.delete();
        exp_pc_q.delete();
        @(negedge i_clk);
        chk("abort_vld_low", 64'(o_inst_vld), 64'(0));
        tick();
        @(negedge i_clk);
        chk("abort_busy_low", 64'(o_busy), 64'(0));
        repeat (4) tick();
        chk("abort_no_done", 64'(done_cnt - d0), 64'(0));
        chk("abort_vld_stays_low", 64'(o_inst_vld), 64'(0));
        run_basic("after_abort");

        d0 = done_cnt;
        r0 = rd_cnt;
        start_prog(12'h123, 13'd0);
        @(negedge i_clk);
        chk("num0_done", 64'(o_done), 64'(1));
        chk("num0_busy", 64'(o_busy), 64'(0));
        repeat (3) tick();
        chk("num0_single_done", 64'(done_cnt - d0), 64'(1));
        chk("num0_no_rd", 64'(rd_cnt - r0), 64'(0));

        d0 = done_cnt;
        r0 = rd_cnt;
        i_abort      = 1'b1;
        i_start      = 1'b1;
        i_start_addr = 12'h055;
        i_inst_num   = 13'd5;
        tick();
        i_abort = 1'b0;
        i_start = 1'b0;
        repeat (4) tick();
        chk("idle_abort_busy", 64'(o_busy), 64'(0));
        chk("idle_abort_no_done", 64'(done_cnt - d0), 64'(0));
        chk("idle_abort_no_rd", 64'(rd_cnt - r0), 64'(0));

        rand_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            start_prog(ADDR_WD'($urandom), (ADDR_WD+1)'($urandom_range(1, 24)));
            i_start      = 1'b1;
            i_start_addr = ADDR_WD'($urandom);
            i_inst_num   = 13'd5;
            tick();
            i_start = 1'b0;
            wait_done(300, "random");
        end
        rand_rdy   = 1'b0;
        i_inst_rdy = 1'b1;

        r0 = rd_cnt;
        start_prog(12'h000, 13'd4096);
        wait_done(4300, "full");
        chk("full_reads", 64'(rd_cnt - r0), 64'(4096));

        i_inst_rdy = 1'b0;
        start_prog(12'h200, 13'd3);
        repeat (8) tick();
        chk("pre_reset_vld", 64'(o_inst_vld), 64'(1));
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        exp_rd_q.delete();
        exp_pc_q.delete();
        check_idle_outputs("mid_reset");
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (3) tick();
        chk("post_reset_vld", 64'(o_inst_vld), 64'(0));
        chk("post_reset_busy", 64'(o_busy), 64'(0));
        run_basic("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
